// File: rtl/v8_adc_pulse_emulator.sv
// v8_adc_pulse_emulator: emulates ADC pulses (linear rise, exponential decay) on a baseline
module v8_adc_pulse_emulator #(
    parameter int SIZE_ADC_DATA = 12,
    parameter int RISE_SHIFT    = 2,
    parameter int DECAY_SHIFT   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     trig,
    input  logic [SIZE_ADC_DATA-1:0] amplitude,
    input  logic [SIZE_ADC_DATA-1:0] baseline,
    input  logic                     auto_en,
    input  logic [15:0]              period,
    output logic [SIZE_ADC_DATA-1:0] output_data,
    output logic                     busy,
    output logic                     pulse_start,
    output logic [7:0]               missed_cnt
);
    localparam int AW = SIZE_ADC_DATA + 2;
    localparam int SW = RISE_SHIFT + 1;
    localparam logic [SIZE_ADC_DATA-1:0] RMASK = SIZE_ADC_DATA'((1 << RISE_SHIFT) - 1);

    typedef enum logic [1:0] {IDLE, RISE, DECAY} state_t;

    state_t                   state_q, state_d;
    logic [AW-1:0]            acc_q, acc_d;
    logic [SIZE_ADC_DATA-1:0] amp_q, amp_d;
    logic [SW-1:0]            step_q, step_d;
    logic [15:0]              cnt_q, cnt_d;
    logic [SIZE_ADC_DATA-1:0] out_q, out_d;
    logic                     ps_q, ps_d;
    logic [7:0]               missed_q, missed_d;

    logic          auto_on, auto_tick, eff, accept, last;
    logic [AW-1:0] inc, rise_acc, dec;
    logic [AW:0]   rise_sum, out_sum;

    // auto-trigger down-counter, held at period-1 while disabled
    always_comb begin
        auto_on   = auto_en && (period != 16'd0);
        auto_tick = auto_on && (cnt_q == 16'd0);
        cnt_d     = !auto_on ? ((period == 16'd0) ? 16'd0 : period - 16'd1)
                  : auto_tick ? period - 16'd1 : cnt_q - 16'd1;
    end

    // datapath helpers: saturating rise step and decay decrement
    always_comb begin
        eff      = trig | auto_tick;
        accept   = eff && (state_q != RISE);
        last     = step_q == SW'((1 << RISE_SHIFT) - 1);
        inc      = AW'(amp_q >> RISE_SHIFT) + (last ? AW'(amp_q & RMASK) : '0);
        rise_sum = {1'b0, acc_q} + {1'b0, inc};
        rise_acc = rise_sum[AW] ? '1 : rise_sum[AW-1:0];
        dec      = acc_q >> DECAY_SHIFT;
        dec      = (dec == '0 && acc_q != '0) ? AW'(1) : dec;
    end

    // next-state: accept in IDLE/DECAY, rise for 2^RISE_SHIFT edges, then decay to IDLE
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        amp_d    = amp_q;
        step_d   = step_q;
        missed_d = missed_q;
        if (accept) begin
            state_d = RISE;
            amp_d   = amplitude;
            step_d  = '0;
        end else if (state_q == RISE) begin
            acc_d  = rise_acc;
            step_d = step_q + SW'(1);
            if (last) state_d = DECAY;
            if (eff && missed_q != 8'hff) missed_d = missed_q + 8'd1;
        end else if (state_q == DECAY) begin
            if (acc_q == '0) state_d = IDLE;
            else acc_d = acc_q - dec;
        end else begin
            acc_d = '0;
        end
        ps_d    = accept;
        out_sum = {{(AW + 1 - SIZE_ADC_DATA){1'b0}}, baseline} + {1'b0, acc_d};
        out_d   = (|out_sum[AW:SIZE_ADC_DATA]) ? '1 : out_sum[SIZE_ADC_DATA-1:0];
    end

    // state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            amp_q    <= '0;
            step_q   <= '0;
            cnt_q    <= '0;
            out_q    <= '0;
            ps_q     <= 1'b0;
            missed_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            amp_q    <= amp_d;
            step_q   <= step_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            ps_q     <= ps_d;
            missed_q <= missed_d;
        end
    end

    assign output_data = out_q;
    assign busy        = state_q != IDLE;
    assign pulse_start = ps_q;
    assign missed_cnt  = missed_q;
endmodule

// File: tb/tb_v8_adc_pulse_emulator.sv
// tb_v8_adc_pulse_emulator: scoreboard bench for the ADC pulse emulator
module tb_v8_adc_pulse_emulator;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        trig = 1'b0;
    logic        auto_en = 1'b0;
    logic [11:0] amplitude = '0;
    logic [11:0] baseline = 12'd100;
    logic [15:0] period = '0;
    logic [11:0] output_data;
    logic        busy;
    logic        pulse_start;
    logic [7:0]  missed_cnt;

    typedef struct {
        int out;
        int busy;
        int ps;
        int missed;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int m_state = 0, m_acc = 0, m_amp = 0, m_step = 0, m_cnt = 0, m_missed = 0, m_ps = 0, m_out = 0;
    int exp_b[4] = '{350, 600, 850, 1100};
    int exp_r[4] = '{350, 600, 850, 1101};

    v8_adc_pulse_emulator #(.SIZE_ADC_DATA(12), .RISE_SHIFT(2), .DECAY_SHIFT(4)) dut (
        .clk(clk), .reset(reset), .trig(trig), .amplitude(amplitude), .baseline(baseline),
        .auto_en(auto_en), .period(period), .output_data(output_data), .busy(busy),
        .pulse_start(pulse_start), .missed_cnt(missed_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_edge();
        int tick, eff, d, inc, p;
        p = int'(period);
        if (reset) begin
            m_state = 0; m_acc = 0; m_amp = 0; m_step = 0; m_cnt = 0; m_missed = 0; m_ps = 0; m_out = 0;
            return;
        end
        tick = (auto_en && p != 0 && m_cnt == 0) ? 1 : 0;
        if (!(auto_en && p != 0)) m_cnt = (p == 0) ? 0 : p - 1;
        else if (tick != 0) m_cnt = p - 1;
        else m_cnt = m_cnt - 1;
        eff = (trig || tick != 0) ? 1 : 0;
        m_ps = 0;
        if (eff != 0 && m_state != 1) begin
            m_amp = int'(amplitude); m_step = 0; m_state = 1; m_ps = 1;
        end else if (m_state == 1) begin
            if (eff != 0 && m_missed < 255) m_missed++;
            inc = m_amp / 4;
            m_step++;
            if (m_step == 4) begin
                inc += m_amp % 4;
                m_state = 2;
            end
            m_acc = (m_acc + inc > 16383) ? 16383 : m_acc + inc;
        end else if (m_state == 2) begin
            if (m_acc == 0) m_state = 0;
            else begin
                d = m_acc / 16;
                if (d == 0) d = 1;
                m_acc -= d;
            end
        end
        m_out = (int'(baseline) + m_acc > 4095) ? 4095 : int'(baseline) + m_acc;
    endtask

    task automatic step();
        exp_t e;
        model_edge();
        e.out = m_out; e.busy = (m_state != 0) ? 1 : 0; e.ps = m_ps; e.missed = m_missed;
        sb.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        e = sb.pop_front();
        chk("sb_out", int'(output_data), e.out);
        chk("sb_busy", int'(busy), e.busy);
        chk("sb_pulse_start", int'(pulse_start), e.ps);
        chk("sb_missed", int'(missed_cnt), e.missed);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 1000) begin
            step();
            n++;
        end
        chk("idle_reached", int'(busy), 0);
    endtask

    initial begin
        int prev, n, last, np;
        reset = 1'b1;
        step();
        step();
        chk("rst_out", int'(output_data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_pulse_start", int'(pulse_start), 0);
        chk("rst_missed", int'(missed_cnt), 0);
        reset = 1'b0;
        step();
        chk("release_out", int'(output_data), 100);

        amplitude = 12'd1000; trig = 1'b1;
        step();
        trig = 1'b0;
        chk("basic_pulse_start", int'(pulse_start), 1);
        chk("basic_e0", int'(output_data), 100);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("basic_rise", int'(output_data), exp_b[i]);
        end
        step();
        chk("basic_e5", int'(output_data), 1038);
        prev = 1038;
        n = 0;
        while (busy && n < 1000) begin
            step();
            chk("basic_monotonic", (int'(output_data) > prev) ? 1 : 0, 0);
            prev = int'(output_data);
            n++;
        end
        chk("basic_idle", int'(busy), 0);
        chk("basic_baseline", int'(output_data), 100);

        amplitude = 12'd1001; trig = 1'b1;
        step();
        trig = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rem_rise", int'(output_data), exp_r[i]);
        end
        wait_idle();

        baseline = 12'd4000; amplitude = 12'd1000; trig = 1'b1;
        step();
        trig = 1'b0;
        chk("sat_e0", int'(output_data), 4000);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("sat_rise", int'(output_data), 4095);
        end
        baseline = 12'd100;
        step();
        chk("sat_acc_peak", int'(output_data), 1038);
        wait_idle();

        amplitude = 12'd1000; trig = 1'b1;
        step();
        trig = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("pile_decay_e5", int'(output_data), 1038);
        trig = 1'b1;
        step();
        trig = 1'b0;
        chk("pile_accept_out", int'(output_data), 1038);
        chk("pile_pulse_start", int'(pulse_start), 1);
        step();
        chk("pile_rise1", int'(output_data), 1288);
        chk("pile_strobe_once", int'(pulse_start), 0);
        trig = 1'b1;
        step();
        trig = 1'b0;
        chk("drop_missed", int'(missed_cnt), 1);
        chk("drop_no_strobe", int'(pulse_start), 0);
        chk("drop_rise2", int'(output_data), 1538);
        step();
        step();
        chk("pile_peak", int'(output_data), 2038);
        wait_idle();

        period = 16'd10;
        step();
        auto_en = 1'b1;
        last = -1;
        np = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (pulse_start) begin
                if (last >= 0) chk("auto_gap", cyc - last, 10);
                last = cyc;
                np++;
            end
        end
        chk("auto_count", np, 6);
        auto_en = 1'b0;
        wait_idle();

        trig = 1'b1;
        step();
        trig = 1'b0;
        step();
        reset = 1'b1;
        step();
        chk("midrise_rst_out", int'(output_data), 0);
        chk("midrise_rst_busy", int'(busy), 0);
        chk("midrise_rst_missed", int'(missed_cnt), 0);
        reset = 1'b0;
        step();
        chk("midrise_release_out", int'(output_data), 100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
